// File: rtl/cram_burst_responder_pkg.sv
// Shared CellularRAM burst constants: BCR field positions, register selects, burst codes,
// responder states and small decode helpers.
package cram_burst_responder_pkg;

    localparam int unsigned BcrOpMode  = 15;
    localparam int unsigned BcrLatHi   = 13;
    localparam int unsigned BcrLatLo   = 11;
    localparam int unsigned BcrWaitPol = 10;
    localparam int unsigned BcrWaitCon = 8;
    localparam int unsigned BcrBurstW  = 3;
    localparam int unsigned BcrBurstHi = 2;

    localparam logic [1:0] SelBcr = 2'b10;
    localparam logic [1:0] SelRcr = 2'b00;

    localparam logic [2:0] Bl4    = 3'b001;
    localparam logic [2:0] Bl8    = 3'b010;
    localparam logic [2:0] Bl16   = 3'b011;
    localparam logic [2:0] BlCont = 3'b111;

    localparam logic [15:0] BcrRstDefault = 16'h9D1F;
    localparam logic [15:0] RcrRstDefault = 16'h0010;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCfg   = 3'd1,
        StLat   = 3'd2,
        StRData = 3'd3,
        StWData = 3'd4,
        StDone  = 3'd5
    } cramStateT;

    // Reserved latency codes fall back to the reset latency of 3.
    function automatic logic [2:0] latCount(input logic [2:0] code);
        return (code >= 3'd2 && code <= 3'd6) ? code : 3'd3;
    endfunction

    // Burst length minus one; zero marks a continuous burst.
    function automatic logic [3:0] burstMask(input logic [2:0] code);
        case (code)
            Bl4:     return 4'd3;
            Bl8:     return 4'd7;
            Bl16:    return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/cram_word_array.sv
// Single-port 16-bit word store with per-byte write enables and a registered read port.
module cram_word_array #(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  Clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [1:0]            byteWe,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    logic [15:0] mem [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge Clk) begin
        if (byteWe[0]) mem[addr][7:0] <= wdata[7:0];
        if (byteWe[1]) mem[addr][15:8] <= wdata[15:8];
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cram_burst_responder.sv
// CellularRAM synchronous-burst memory model: config register writes, latency-timed fixed and
// continuous bursts, WAIT generation and byte-masked writes into a small word array.
module cram_burst_responder
    import cram_burst_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [15:0] BCR_RST    = BcrRstDefault,
    parameter logic [15:0] RCR_RST    = RcrRstDefault
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        CeN,
    input  logic        AdvN,
    input  logic        WeN,
    input  logic        Cre,
    input  logic        LbN,
    input  logic        UbN,
    input  logic [19:0] MemAdr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        DataOe,
    output logic        Wait,
    output logic [15:0] BcrOut,
    output logic [15:0] RcrOut
);

    cramStateT             stateQ;
    logic [15:0]           bcrQ, rcrQ;
    logic [DEPTH_LOG2-1:0] addrQ;
    logic [2:0]            cycQ, lcQ;
    logic [3:0]            beatQ, maskQ;
    logic                  wrapQ, waitConQ, writeQ;

    logic                  accStart, cfgWrite, arrAccess, readBeat, writeBeat, lastBeat;
    logic [DEPTH_LOG2-1:0] addrInc, maskW, addrNext, arrAddr;
    logic [1:0]            byteWe;
    logic [15:0]           arrRdata;
    logic [2:0]            waitEnd;
    logic [1:0]            unusedAdr;

    assign accStart  = !CeN && !AdvN;
    assign cfgWrite  = accStart && Cre && !WeN;
    assign arrAccess = accStart && !Cre && !bcrQ[BcrOpMode];
    // A new access start outranks burst progression at the same edge.
    assign readBeat  = (stateQ == StRData) && !CeN && !accStart;
    assign writeBeat = (stateQ == StWData) && !CeN && !accStart;
    assign lastBeat  = (maskQ != 4'd0) && (beatQ == maskQ);

    assign addrInc  = addrQ + DEPTH_LOG2'(1);
    assign maskW    = DEPTH_LOG2'(maskQ);
    assign addrNext = wrapQ ? ((addrQ & ~maskW) | (addrInc & maskW)) : addrInc;
    assign waitEnd  = waitConQ ? (lcQ - 3'd1) : lcQ;
    assign byteWe   = writeBeat ? {~UbN, ~LbN} : 2'b00;

    assign BcrOut    = bcrQ;
    assign RcrOut    = rcrQ;
    assign unusedAdr = MemAdr[17:16];

    // Reads look one word ahead so the registered array output is ready at the emit edge.
    always_comb begin
        arrAddr = addrQ;
        if (writeBeat) begin
            arrAddr = addrQ;
        end else if (readBeat) begin
            arrAddr = addrNext;
        end else if (arrAccess) begin
            arrAddr = MemAdr[DEPTH_LOG2-1:0];
        end
    end

    cram_word_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) wordArray (
        .Clk   (Clk),
        .addr  (arrAddr),
        .byteWe(byteWe),
        .wdata (DataIn),
        .rdata (arrRdata)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateQ   <= StIdle;
            bcrQ     <= BCR_RST;
            rcrQ     <= RCR_RST;
            addrQ    <= '0;
            cycQ     <= 3'd0;
            lcQ      <= 3'd3;
            beatQ    <= 4'd0;
            maskQ    <= 4'd0;
            wrapQ    <= 1'b0;
            waitConQ <= 1'b0;
            writeQ   <= 1'b0;
            DataOut  <= 16'h0000;
            DataOe   <= 1'b0;
            Wait     <= 1'b0;
        end else begin
            DataOe <= 1'b0;
            Wait   <= ~bcrQ[BcrWaitPol];
            if (CeN) begin
                stateQ <= StIdle;
            end else if (accStart) begin
                stateQ <= StIdle;
                if (cfgWrite) begin
                    stateQ <= StCfg;
                    if (MemAdr[19:18] == SelBcr) begin
                        bcrQ <= MemAdr[15:0];
                    end else if (MemAdr[19:18] == SelRcr) begin
                        rcrQ <= MemAdr[15:0];
                    end
                end else if (arrAccess) begin
                    stateQ   <= StLat;
                    addrQ    <= MemAdr[DEPTH_LOG2-1:0];
                    cycQ     <= 3'd1;
                    beatQ    <= 4'd0;
                    lcQ      <= latCount(bcrQ[BcrLatHi:BcrLatLo]);
                    maskQ    <= burstMask(bcrQ[BcrBurstHi:0]);
                    wrapQ    <= !bcrQ[BcrBurstW] && (burstMask(bcrQ[BcrBurstHi:0]) != 4'd0);
                    waitConQ <= bcrQ[BcrWaitCon];
                    writeQ   <= !WeN;
                    Wait     <= bcrQ[BcrWaitPol];
                end
            end else begin
                if (cycQ != 3'd7) cycQ <= cycQ + 3'd1;
                case (stateQ)
                    StCfg: stateQ <= StIdle;
                    StLat: begin
                        if (cycQ < waitEnd) Wait <= bcrQ[BcrWaitPol];
                        // Writes take their first word one edge later than reads emit theirs.
                        if (writeQ && cycQ == lcQ) begin
                            stateQ <= StWData;
                        end else if (!writeQ && cycQ == lcQ - 3'd1) begin
                            stateQ <= StRData;
                        end
                    end
                    StRData, StWData: begin
                        if (stateQ == StRData) begin
                            DataOut <= arrRdata;
                            DataOe  <= 1'b1;
                        end
                        addrQ <= addrNext;
                        beatQ <= beatQ + 4'd1;
                        if (lastBeat) stateQ <= StDone;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cram_burst_responder.sv
// Directed bench: per-edge expectation schedule built from the timing rules, checked every cycle.
module tb_cram_burst_responder;

    logic        Clk, Rst_n, CeN, AdvN, WeN, Cre, LbN, UbN;
    logic [19:0] MemAdr;
    logic [15:0] DataIn, DataOut, BcrOut, RcrOut;
    logic        DataOe, Wait;

    cram_burst_responder dut (
        .Clk(Clk), .Rst_n(Rst_n), .CeN(CeN), .AdvN(AdvN), .WeN(WeN), .Cre(Cre),
        .LbN(LbN), .UbN(UbN), .MemAdr(MemAdr), .DataIn(DataIn), .DataOut(DataOut),
        .DataOe(DataOe), .Wait(Wait), .BcrOut(BcrOut), .RcrOut(RcrOut)
    );

    int          total = 0;
    int          bad = 0;
    int          edgeN = 0;
    bit          chkOn = 0;
    bit          expOe [0:8191];
    bit          expWait [0:8191];
    logic [15:0] expOut [0:8191];
    logic [15:0] mdl [0:255];
    logic [15:0] wData [0:15];
    bit          wLb [0:15];
    bit          wUb [0:15];
    logic [15:0] cap [$];
    int          firstOe, lastWait, e0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) edgeN++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", nm, act, want, edgeN);
        end
    endtask

    always @(negedge Clk) begin
        if (chkOn) begin
            chk("oe", {31'd0, DataOe}, {31'd0, expOe[edgeN]});
            chk("wait", {31'd0, Wait}, {31'd0, expWait[edgeN]});
            if (expOe[edgeN]) chk("dout", {16'd0, DataOut}, {16'd0, expOut[edgeN]});
            if (DataOe) begin
                if (cap.size() == 0) firstOe = edgeN;
                cap.push_back(DataOut);
            end
            if (Wait) lastWait = edgeN;
        end
    end

    function automatic int seqAddr(input int base, input int k, input int bl, input bit wrap);
        if (wrap && bl > 0) return (base - base % bl) + (base + k) % bl;
        return (base + k) % 256;
    endfunction

    task automatic setWords(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3);
        wData[0] = w0; wData[1] = w1; wData[2] = w2; wData[3] = w3;
        for (int i = 0; i < 16; i++) begin
            wLb[i] = 1'b0;
            wUb[i] = 1'b0;
        end
    endtask

    task automatic cfg(input logic [19:0] adr);
        @(negedge Clk);
        CeN = 0; AdvN = 0; Cre = 1; WeN = 0; MemAdr = adr;
        @(negedge Clk);
        CeN = 1; AdvN = 1; Cre = 0; WeN = 1;
    endtask

    // One burst; rstAt >= 0 pulls reset while data word rstAt is on the bus.
    task automatic access(input bit isWr, input int base, input int n, input int lc,
                          input bit wcon, input int bl, input bit wrap, input int tail,
                          input int rstAt, output int start);
        int wEnd, a, last;
        @(negedge Clk);
        start = edgeN + 1;
        wEnd = wcon ? lc - 1 : lc;
        for (int e = start; e < start + wEnd; e++) expWait[e] = 1'b1;
        if (!isWr) begin
            for (int k = 0; k < n; k++) begin
                a = seqAddr(base, k, bl, wrap);
                expOe[start + lc + k] = 1'b1;
                expOut[start + lc + k] = mdl[a];
            end
        end
        CeN = 0; AdvN = 0; Cre = 0; WeN = !isWr; MemAdr = 20'(base);
        @(negedge Clk);
        AdvN = 1; WeN = 1; MemAdr = 20'h0;
        if (isWr) begin
            for (int k = 0; k < n; k++) begin
                while (edgeN < start + lc + k) @(negedge Clk);
                a = seqAddr(base, k, bl, wrap);
                DataIn = wData[k]; LbN = wLb[k]; UbN = wUb[k];
                if (!wLb[k]) mdl[a][7:0] = wData[k][7:0];
                if (!wUb[k]) mdl[a][15:8] = wData[k][15:8];
            end
        end
        if (rstAt >= 0) begin
            while (edgeN < start + lc + rstAt) @(negedge Clk);
            #2 Rst_n = 0;
            #1;
            chk("rstOe", {31'd0, DataOe}, 32'd0);
            chk("rstWait", {31'd0, Wait}, 32'd0);
            chk("rstDout", {16'd0, DataOut}, 32'h0);
            chk("rstBcr", {16'd0, BcrOut}, 32'h9D1F);
            for (int e = edgeN + 1; e < 8192; e++) begin
                expOe[e] = 1'b0;
                expWait[e] = 1'b0;
            end
            @(negedge Clk);
            CeN = 1; Rst_n = 1;
            @(negedge Clk);
        end else begin
            last = isWr ? start + lc + n : start + lc + n - 1;
            while (edgeN < last + tail) @(negedge Clk);
            CeN = 1; LbN = 0; UbN = 0;
            @(negedge Clk);
        end
    endtask

    initial begin
        Rst_n = 1; CeN = 1; AdvN = 1; WeN = 1; Cre = 0; LbN = 0; UbN = 0;
        MemAdr = 20'h0; DataIn = 16'h0; firstOe = 0; lastWait = 0;
        #1 Rst_n = 0;
        @(negedge Clk);
        @(negedge Clk);
        chk("resetOe", {31'd0, DataOe}, 32'd0);
        chk("resetWait", {31'd0, Wait}, 32'd0);
        chk("resetDout", {16'd0, DataOut}, 32'h0);
        chk("resetBcr", {16'd0, BcrOut}, 32'h9D1F);
        chk("resetRcr", {16'd0, RcrOut}, 32'h0010);
        Rst_n = 1;
        chkOn = 1;

        // Async OpMode after reset: a read start must produce no bus or WAIT activity.
        cap.delete();
        @(negedge Clk);
        CeN = 0; AdvN = 0; MemAdr = 20'h00010;
        @(negedge Clk);
        AdvN = 1;
        repeat (7) @(negedge Clk);
        CeN = 1;
        @(negedge Clk);
        chk("asyncNoOe", cap.size(), 0);

        cfg(20'h81D1F);
        chk("bcrLoad", {16'd0, BcrOut}, 32'h1D1F);
        cfg(20'h00010);
        chk("rcrLoad", {16'd0, RcrOut}, 32'h0010);
        cfg(20'h4ABCD);
        chk("selIgnoredBcr", {16'd0, BcrOut}, 32'h1D1F);
        chk("selIgnoredRcr", {16'd0, RcrOut}, 32'h0010);

        // LC 3, BL 4, no wrap, WaitCon 1.
        cfg(20'h81D19);
        setWords(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        access(1, 16'h10, 4, 3, 1, 4, 0, 2, -1, e0);
        setWords(16'hA001, 16'hA002, 16'hA003, 16'hA004);
        wUb[1] = 1'b1;
        access(1, 16'h10, 4, 3, 1, 4, 0, 2, -1, e0);
        cap.delete();
        access(0, 16'h10, 4, 3, 1, 4, 0, 2, -1, e0);
        chk("rdCount", cap.size(), 4);
        chk("rdW0", {16'd0, cap[0]}, 32'hA001);
        chk("rdW1Masked", {16'd0, cap[1]}, 32'h2202);
        chk("rdW2", {16'd0, cap[2]}, 32'hA003);
        chk("rdW3", {16'd0, cap[3]}, 32'hA004);
        chk("firstDataEdge", firstOe - e0, 3);
        chk("waitLastEdge", lastWait - e0, 1);

        // Wrapping BL 4 read starting mid-block.
        cfg(20'h81D11);
        setWords(16'h0404, 16'h0505, 16'h0606, 16'h0707);
        access(1, 16'h04, 4, 3, 1, 4, 1, 1, -1, e0);
        cap.delete();
        access(0, 16'h06, 4, 3, 1, 4, 1, 3, -1, e0);
        chk("wrapCount", cap.size(), 4);
        chk("wrapW0", {16'd0, cap[0]}, 32'h0606);
        chk("wrapW2", {16'd0, cap[2]}, 32'h0404);
        chk("wrapW3", {16'd0, cap[3]}, 32'h0505);

        // Continuous burst across the top of the array, stopped by CeN.
        cfg(20'h81D1F);
        setWords(16'hC0FE, 16'hC0FF, 16'hC000, 16'hC001);
        access(1, 16'hFE, 4, 3, 1, 0, 0, 0, -1, e0);
        cap.delete();
        access(0, 16'hFE, 4, 3, 1, 0, 0, 0, -1, e0);
        chk("contCount", cap.size(), 4);
        chk("contW1", {16'd0, cap[1]}, 32'hC0FF);
        chk("contW2", {16'd0, cap[2]}, 32'hC000);

        // LC 2 with WaitCon 0, then reserved LatCount 7 behaving as 3.
        cfg(20'h81419);
        access(0, 16'h10, 4, 2, 0, 4, 0, 2, -1, e0);
        cfg(20'h83D19);
        access(0, 16'h10, 4, 3, 1, 4, 0, 2, -1, e0);

        // Reset during the second data word.
        cfg(20'h81D19);
        access(0, 16'h10, 4, 3, 1, 4, 0, 0, 1, e0);
        chk("postRstRcr", {16'd0, RcrOut}, 32'h0010);
        repeat (3) @(negedge Clk);

        chkOn = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
